// File: rtl/scr1_pipe_lsu_mo.sv
// Pipelined LSU with up to OUTSTD in-flight DMEM accesses tracked in an in-order FIFO.
// Define SCR1_LSU_ERR_ADDR_EN to keep full addresses per entry and report lsu2exu_err_addr_o.
module scr1_pipe_lsu_mo #(
   parameter int OUTSTD = 2,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              exu2lsu_req_i,
   input  logic [3:0]        exu2lsu_cmd_i,
   input  logic [AWIDTH-1:0] exu2lsu_addr_i,
   input  logic [31:0]       exu2lsu_sdata_i,
   input  logic              exu2lsu_flush_i,
   output logic              lsu2exu_ack_o,
   output logic              lsu2exu_rdy_o,
   output logic [31:0]       lsu2exu_ldata_o,
   output logic              lsu2exu_exc_o,
   output logic [3:0]        lsu2exu_exc_code_o,
   output logic              lsu2exu_busy_o,
   output logic              lsu2dmem_req_o,
   output logic              lsu2dmem_cmd_o,
   output logic [1:0]        lsu2dmem_width_o,
   output logic [AWIDTH-1:0] lsu2dmem_addr_o,
   output logic [31:0]       lsu2dmem_wdata_o,
   input  logic              dmem2lsu_req_ack_i,
   input  logic [31:0]       dmem2lsu_rdata_i,
   input  logic [1:0]        dmem2lsu_resp_i
`ifdef SCR1_LSU_ERR_ADDR_EN
   ,
   output logic [AWIDTH-1:0] lsu2exu_err_addr_o
`endif
);

   typedef enum logic [3:0] {
      LSU_CMD_NONE = 4'd0,
      LSU_CMD_LB   = 4'd1,
      LSU_CMD_LH   = 4'd2,
      LSU_CMD_LW   = 4'd3,
      LSU_CMD_LBU  = 4'd4,
      LSU_CMD_LHU  = 4'd5,
      LSU_CMD_SB   = 4'd6,
      LSU_CMD_SH   = 4'd7,
      LSU_CMD_SW   = 4'd8
   } type_scr1_lsu_cmd_sel_e;

   localparam logic       MEM_CMD_RD   = 1'b0;
   localparam logic       MEM_CMD_WR   = 1'b1;
   localparam logic [1:0] MEM_W_BYTE   = 2'd0;
   localparam logic [1:0] MEM_W_HWORD  = 2'd1;
   localparam logic [1:0] MEM_W_WORD   = 2'd2;
   localparam logic [1:0] MEM_RESP_NR  = 2'd0;
   localparam logic [1:0] MEM_RESP_OK  = 2'd1;
   localparam logic [1:0] MEM_RESP_ER  = 2'd2;

   localparam logic [3:0] EXC_LD_MSLGN = 4'd4;
   localparam logic [3:0] EXC_LD_FAULT = 4'd5;
   localparam logic [3:0] EXC_ST_MSLGN = 4'd6;
   localparam logic [3:0] EXC_ST_FAULT = 4'd7;

   localparam int PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
   localparam int CW = $clog2(OUTSTD + 1);

   typedef struct packed {
      type_scr1_lsu_cmd_sel_e cmd;
      logic [1:0]             off;
`ifdef SCR1_LSU_ERR_ADDR_EN
      logic [AWIDTH-1:0]      addr;
`endif
   } fifo_entry_t;

   fifo_entry_t             r_mem [OUTSTD];
   logic [OUTSTD-1:0]       r_vld;
   logic [OUTSTD-1:0]       r_kill;
   logic [PW-1:0]           r_wptr;
   logic [PW-1:0]           r_rptr;
   logic [CW-1:0]           r_cnt;

   type_scr1_lsu_cmd_sel_e  w_cmd;
   fifo_entry_t             w_head;
   fifo_entry_t             w_new;
   logic                    w_empty, w_full;
   logic                    w_is_st, w_head_st;
   logic                    w_mslgn, w_mslgn_exc;
   logic                    w_push, w_pop, w_resp_vis;
   logic [31:0]             w_rsh_b, w_rsh_h;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(OUTSTD - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_cmd     = type_scr1_lsu_cmd_sel_e'(exu2lsu_cmd_i);
   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == CW'(OUTSTD));
   assign w_head    = r_mem[r_rptr];
   assign w_is_st   = w_cmd inside {LSU_CMD_SB, LSU_CMD_SH, LSU_CMD_SW};
   assign w_head_st = w_head.cmd inside {LSU_CMD_SB, LSU_CMD_SH, LSU_CMD_SW};

   assign w_mslgn = ((w_cmd inside {LSU_CMD_LH, LSU_CMD_LHU, LSU_CMD_SH}) & exu2lsu_addr_i[0])
                  | ((w_cmd inside {LSU_CMD_LW, LSU_CMD_SW}) & (|exu2lsu_addr_i[1:0]));
   // A misaligned access waits for older accesses to retire so exceptions stay in order.
   assign w_mslgn_exc = exu2lsu_req_i & w_mslgn & w_empty;

   assign lsu2dmem_req_o = rst_n & exu2lsu_req_i & ~w_mslgn & ~w_full & ~exu2lsu_flush_i;
   assign w_push         = lsu2dmem_req_o & dmem2lsu_req_ack_i;
   assign lsu2exu_ack_o  = w_push;
   assign w_pop          = (dmem2lsu_resp_i != MEM_RESP_NR) & ~w_empty;
   assign w_resp_vis     = w_pop & ~r_kill[r_rptr] & ~exu2lsu_flush_i;
   assign lsu2exu_busy_o = ~w_empty;

   assign lsu2dmem_addr_o = exu2lsu_addr_i;
   assign lsu2dmem_cmd_o  = w_is_st ? MEM_CMD_WR : MEM_CMD_RD;
   assign w_rsh_b = dmem2lsu_rdata_i >> {w_head.off, 3'b000};
   assign w_rsh_h = dmem2lsu_rdata_i >> {w_head.off[1], 4'b0000};

   always_comb begin
      w_new     = '0;
      w_new.cmd = w_cmd;
      w_new.off = exu2lsu_addr_i[1:0];
`ifdef SCR1_LSU_ERR_ADDR_EN
      w_new.addr = exu2lsu_addr_i;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_kill <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (exu2lsu_flush_i) r_kill <= r_kill | r_vld;
         if (w_push) begin
            r_vld[r_wptr]  <= 1'b1;
            r_kill[r_wptr] <= 1'b0;
            r_wptr         <= next_ptr(r_wptr);
         end
         if (w_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= next_ptr(r_rptr);
         end
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   // NOTE: payload storage has no reset; r_vld/r_kill alone decide whether an entry means anything.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_new;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      lsu2dmem_width_o   = MEM_W_WORD;
      lsu2dmem_wdata_o   = exu2lsu_sdata_i;
      lsu2exu_rdy_o      = 1'b0;
      lsu2exu_exc_o      = 1'b0;
      lsu2exu_exc_code_o = '0;
      lsu2exu_ldata_o    = '0;
`ifdef SCR1_LSU_ERR_ADDR_EN
      lsu2exu_err_addr_o = '0;
`endif
      case (w_cmd)
         LSU_CMD_LB, LSU_CMD_LBU: lsu2dmem_width_o = MEM_W_BYTE;
         LSU_CMD_SB: begin
            lsu2dmem_width_o = MEM_W_BYTE;
            lsu2dmem_wdata_o = {4{exu2lsu_sdata_i[7:0]}};
         end
         LSU_CMD_LH, LSU_CMD_LHU: lsu2dmem_width_o = MEM_W_HWORD;
         LSU_CMD_SH: begin
            lsu2dmem_width_o = MEM_W_HWORD;
            lsu2dmem_wdata_o = {2{exu2lsu_sdata_i[15:0]}};
         end
         default: ;
      endcase

      if (w_mslgn_exc) begin
         lsu2exu_rdy_o      = 1'b1;
         lsu2exu_exc_o      = 1'b1;
         lsu2exu_exc_code_o = w_is_st ? EXC_ST_MSLGN : EXC_LD_MSLGN;
`ifdef SCR1_LSU_ERR_ADDR_EN
         lsu2exu_err_addr_o = exu2lsu_addr_i;
`endif
      end else if (w_resp_vis) begin
         lsu2exu_rdy_o = 1'b1;
         if (dmem2lsu_resp_i == MEM_RESP_ER) begin
            lsu2exu_exc_o      = 1'b1;
            lsu2exu_exc_code_o = w_head_st ? EXC_ST_FAULT : EXC_LD_FAULT;
`ifdef SCR1_LSU_ERR_ADDR_EN
            lsu2exu_err_addr_o = w_head.addr;
`endif
         end else if (dmem2lsu_resp_i == MEM_RESP_OK) begin
            case (w_head.cmd)
               LSU_CMD_LB:  lsu2exu_ldata_o = {{24{w_rsh_b[7]}}, w_rsh_b[7:0]};
               LSU_CMD_LBU: lsu2exu_ldata_o = {24'd0, w_rsh_b[7:0]};
               LSU_CMD_LH:  lsu2exu_ldata_o = {{16{w_rsh_h[15]}}, w_rsh_h[15:0]};
               LSU_CMD_LHU: lsu2exu_ldata_o = {16'd0, w_rsh_h[15:0]};
               LSU_CMD_LW:  lsu2exu_ldata_o = dmem2lsu_rdata_i;
               default:     lsu2exu_ldata_o = '0;
            endcase
         end
      end
   end

   // A DMEM response with nothing outstanding indicates a broken memory-side protocol.
   a_resp_needs_entry: assert property (@(posedge clk) disable iff (!rst_n)
      (dmem2lsu_resp_i != MEM_RESP_NR) |-> !w_empty);

endmodule
